game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Central Space Invaders game controller, parametrised in invader grid, bolt counts and lives.
//  Detects pixel-level collisions from the draw-request lines of every sprite during the frame.
//  Accumulates the detected hits and commits them once per frame.
//  Owns invader/boss/player existence, score, lives and the stage/play/over sequencing.
// PARAMETERS
//  INV_ROWS   8   invader grid rows
//  INV_COLS   16  invader grid columns
//  CELL_LOG2  5   log2 of invader cell size in px; cell index = offset >> CELL_LOG2
//  PBOLTS     4   player bolt channels
//  IBOLTS     4   invader bolt channels
//  PLR_LIVES  3   player lives per game (1..7)
//  BOSS_LIVES 20  boss hits to kill
//  SCORE_W    10  score width; saturating
//  INV_PTS    1   points per invader; BOSS_PTS 10 points per boss kill
//  DEAD_SECS  2   oneSec ticks spent in S_DEAD
// PORTS
//  clk        in  1   system clock
//  resetN     in  1   asynchronous active-low reset
//  startOfFrame in 1  one-cycle pulse at frame start; commit point
//  spcKey     in  1   start/continue key, level
//  oneSec     in  1   one-cycle pulse per second
//  plrReq     in  1   player drawing current pixel
//  invReq     in  1   invader block drawing current pixel
//  invOSX     in  11  pixel offset inside invader block, X
//  invOSY     in  11  pixel offset inside invader block, Y
//  lrrReq     in  1   boss drawing current pixel
//  btpReq     in  PBOLTS  player bolt i drawing
//  btiReq     in  IBOLTS  invader bolt j drawing
//  cheatput   in  1   invulnerability request (used only with CHEAT_EN)
//  plrExs     out 1   player alive/displayed
//  plrHit     out 1   one-cycle pulse, player hit committed
//  invExs     out [INV_ROWS][INV_COLS]  invader alive map
//  invHit     out [INV_ROWS][INV_COLS]  one-cycle pulse per killed cell
//  lrrExs     out 1   boss alive; lrrHit out 1 pulse per committed boss hit
//  btpKil     out PBOLTS  one-cycle kill pulse to player bolt i
//  btiKil     out IBOLTS  one-cycle kill pulse to invader bolt j
//  stgMsg, scrMsg, edgMsg out 1  stage / score / end-of-game message enables
//  scrNum     out SCORE_W  score; scrLiv out 3  lives left
// BEHAVIOUR
//  Reset: state S_STAGE; invExs all 1; lrrExs 1; boss ctr BOSS_LIVES; plrExs 1; scrNum 0; scrLiv PLR_LIVES;
//   stgMsg 1; scrMsg 0; edgMsg 0; all pulses 0.
//  FSM: S_STAGE --spcKey--> S_PLAY.
//   S_PLAY --player hit commit, scrLiv>1--> S_DEAD, scrLiv-1.
//   S_PLAY --player hit commit, scrLiv==1--> S_OVER, scrLiv 0.
//   S_PLAY --last invader and boss dead--> S_STAGE: grid/boss refilled, score and lives kept.
//   S_DEAD --DEAD_SECS oneSec ticks--> S_PLAY, plrExs 1. S_OVER --spcKey--> S_STAGE as after reset.
//  Messages: stgMsg=S_STAGE; scrMsg=S_PLAY|S_DEAD; edgMsg=S_OVER. plrExs 0 in S_DEAD/S_OVER.
//  Detection, S_PLAY only, every cycle:
//   btpReq[i]&invReq&invExs[r][c] -> pend cell; r=invOSY>>CELL_LOG2, c=invOSX>>CELL_LOG2.
//   Out-of-range r/c ignored.
//   btpReq[i]&lrrReq&lrrExs -> pend boss hit.
//   btiReq[j]&plrReq&plrExs -> pend player hit.
//  Bolt kills: btpKil/btiKil pulse on the cycle after detection (1-cycle latency); the bolt is removed mid-frame.
//  Commit on startOfFrame: invExs &= ~pend; invHit=pend for 1 cycle.
//   Score += INV_PTS*popcount(pend) + BOSS_PTS on boss kill; saturates at 2^SCORE_W-1.
//   Boss counter decrements by 1 per frame regardless of how many bolts hit; lrrHit pulses; at 0 lrrExs=0.
//   All pend bits cleared.
//  Simultaneous: the player hit and the last enemy falling in one frame -> player hit wins (life lost); the enemy kills still score.
//  Detection and startOfFrame on the same cycle -> that hit lands in the next frame's pend.
//  Pend cleared on any state exit; resetN mid-frame discards all pend.
// CONFIGURATION
//  GAME_CHEAT_EN defined: cheatput=1 masks the player-hit pend; invader bolts still get btiKil.
//  GAME_CHEAT_EN undefined: cheatput ignored; no logic generated for it.
// STRUCTURE
//  game_pkg holds: state_t {S_STAGE,S_PLAY,S_DEAD,S_OVER}; default constants; cell-index function.
//  Sub-module score_accum: popcount, weighted add and saturation, registered.
// TESTING
//  Reset, spcKey 1 cycle -> stgMsg 0, scrMsg 1, scrLiv 3, scrNum 0.
//  btpReq[0]&invReq, offset (70,40) -> btpKil[0] next cycle.
//   Next startOfFrame -> invHit[1][2] pulse, invExs[1][2]=0, scrNum 1.
//  Two bolts hit the boss in one frame -> lrrHit once; boss ctr 19; 20 frames of hits -> lrrExs 0, scrNum +10.
//  Player hit in the same frame as the last invader/boss kill -> scrLiv 2, state S_DEAD.
//   After 2 oneSec ticks -> S_PLAY; grid refilled only after the next S_PLAY clear.
//  3 player hits -> S_OVER, edgMsg 1, scrLiv 0; spcKey -> S_STAGE, full reset values.
//  Score at 1023 plus a kill -> stays 1023; with GAME_CHEAT_EN and cheatput=1, a player hit -> scrLiv unchanged.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and defaults for the Space Invaders game controller.
//   state_t   : game sequencing states
//   DEF_*     : default parameter values for game_state_ctrl
//   cell_idx  : pixel offset inside the invader block -> grid cell index
package game_pkg;

    typedef enum logic [1:0] {S_STAGE, S_PLAY, S_DEAD, S_OVER} state_t;

    localparam int DEF_INV_ROWS   = 8;
    localparam int DEF_INV_COLS   = 16;
    localparam int DEF_CELL_LOG2  = 5;
    localparam int DEF_PBOLTS     = 4;
    localparam int DEF_IBOLTS     = 4;
    localparam int DEF_PLR_LIVES  = 3;
    localparam int DEF_BOSS_LIVES = 20;
    localparam int DEF_SCORE_W    = 10;
    localparam int DEF_INV_PTS    = 1;
    localparam int DEF_BOSS_PTS   = 10;
    localparam int DEF_DEAD_SECS  = 2;

    function automatic logic [10:0] cell_idx(input logic [10:0] ofs, input int unsigned sh);
        return ofs >> sh;
    endfunction

endpackage

// File: rtl/score_accum.sv
// Registered score accumulator.
//   clk, resetN : clock, async active-low reset
//   clr         : zero the score (new game)
//   en          : commit strobe, adds this frame's kills
//   kills       : one bit per invader killed this frame
//   boss_kill   : boss died this frame
//   score       : saturating score
module score_accum #(
    parameter int N        = 128,
    parameter int SCORE_W  = 10,
    parameter int INV_PTS  = 1,
    parameter int BOSS_PTS = 10
)(
    input  logic               clk,
    input  logic               resetN,
    input  logic               clr,
    input  logic               en,
    input  logic [N-1:0]       kills,
    input  logic               boss_kill,
    output logic [SCORE_W-1:0] score
);

    localparam int CW = $clog2(N + 1);
    localparam logic [SCORE_W-1:0] SMAX = '1;
    localparam logic [31:0] SMAX32 = 32'(SMAX);

    logic [CW-1:0] cnt;
    logic [31:0]   sum;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + CW'(kills[i]);
        // 32-bit sum leaves ample headroom before the saturation compare
        sum = 32'(score) + 32'(cnt) * 32'(INV_PTS) + (boss_kill ? 32'(BOSS_PTS) : 32'd0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)  score <= '0;
        else if (clr) score <= '0;
        else if (en)  score <= (sum > SMAX32) ? SMAX : sum[SCORE_W-1:0];
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Central Space Invaders game controller: pixel collision detection, per-frame
// hit commit, invader/boss/player existence, score, lives, stage sequencing.
// Optional macro GAME_CHEAT_EN: cheatput=1 masks player hits (bolts still die).
// Ports:
//   clk, resetN          clock, async active-low reset
//   startOfFrame         frame-start pulse, commit point for pending hits
//   spcKey, oneSec       start key (level), 1 Hz tick pulse
//   plrReq/invReq/lrrReq sprite draw requests; invOSX/invOSY offset in invader block
//   btpReq/btiReq        player / invader bolt draw requests
//   cheatput             invulnerability request
//   plrExs/invExs/lrrExs existence; plrHit/invHit/lrrHit commit pulses
//   btpKil/btiKil        bolt kill pulses, one cycle after detection
//   stgMsg/scrMsg/edgMsg message enables; scrNum score; scrLiv lives left
module game_state_ctrl import game_pkg::*; #(
    parameter int INV_ROWS   = DEF_INV_ROWS,
    parameter int INV_COLS   = DEF_INV_COLS,
    parameter int CELL_LOG2  = DEF_CELL_LOG2,
    parameter int PBOLTS     = DEF_PBOLTS,
    parameter int IBOLTS     = DEF_IBOLTS,
    parameter int PLR_LIVES  = DEF_PLR_LIVES,
    parameter int BOSS_LIVES = DEF_BOSS_LIVES,
    parameter int SCORE_W    = DEF_SCORE_W,
    parameter int INV_PTS    = DEF_INV_PTS,
    parameter int BOSS_PTS   = DEF_BOSS_PTS,
    parameter int DEAD_SECS  = DEF_DEAD_SECS
)(
    input  logic                               clk,
    input  logic                               resetN,
    input  logic                               startOfFrame,
    input  logic                               spcKey,
    input  logic                               oneSec,
    input  logic                               plrReq,
    input  logic                               invReq,
    input  logic [10:0]                        invOSX,
    input  logic [10:0]                        invOSY,
    input  logic                               lrrReq,
    input  logic [PBOLTS-1:0]                  btpReq,
    input  logic [IBOLTS-1:0]                  btiReq,
    input  logic                               cheatput,
    output logic                               plrExs,
    output logic                               plrHit,
    output logic [INV_ROWS-1:0][INV_COLS-1:0]  invExs,
    output logic [INV_ROWS-1:0][INV_COLS-1:0]  invHit,
    output logic                               lrrExs,
    output logic                               lrrHit,
    output logic [PBOLTS-1:0]                  btpKil,
    output logic [IBOLTS-1:0]                  btiKil,
    output logic                               stgMsg,
    output logic                               scrMsg,
    output logic                               edgMsg,
    output logic [SCORE_W-1:0]                 scrNum,
    output logic [2:0]                         scrLiv
);

    localparam int RW = (INV_ROWS > 1) ? $clog2(INV_ROWS) : 1;
    localparam int CW = (INV_COLS > 1) ? $clog2(INV_COLS) : 1;
    localparam int BW = $clog2(BOSS_LIVES + 1);
    localparam int DW = $clog2(DEAD_SECS + 1);

    state_t state, state_n;

    logic [INV_ROWS-1:0][INV_COLS-1:0] pend_inv, det_vec, inv_after;
    logic pend_boss, pend_plr;
    logic [BW-1:0] boss_ctr;
    logic [DW-1:0] dead_cnt;

    logic [10:0] row, col;
    logic in_rng, play, commit, inv_det, boss_det, plr_raw, plr_det;
    logic boss_kill, plr_commit, all_clear, refill, new_game;

    assign row    = cell_idx(invOSY, CELL_LOG2);
    assign col    = cell_idx(invOSX, CELL_LOG2);
    assign in_rng = (32'(row) < INV_ROWS) && (32'(col) < INV_COLS);
    assign play   = (state == S_PLAY);
    assign commit = play & startOfFrame;

    // Invader grid shares one pixel position for all bolts, so any bolt hits the same cell
    assign inv_det  = play & (|btpReq) & invReq & in_rng & invExs[row[RW-1:0]][col[CW-1:0]];
    assign boss_det = play & (|btpReq) & lrrReq & lrrExs;
    assign plr_raw  = play & (|btiReq) & plrReq & plrExs;

`ifdef GAME_CHEAT_EN
    assign plr_det = plr_raw & ~cheatput;
`else
    logic cheat_unused;
    assign cheat_unused = cheatput;
    assign plr_det = plr_raw;
`endif

    always_comb begin
        det_vec = '0;
        if (inv_det) det_vec[row[RW-1:0]][col[CW-1:0]] = 1'b1;
    end

    assign boss_kill  = commit & pend_boss & (boss_ctr == BW'(1));
    assign plr_commit = commit & pend_plr;
    assign inv_after  = commit ? (invExs & ~pend_inv) : invExs;
    assign all_clear  = (inv_after == '0) && !(lrrExs & ~boss_kill);
    assign refill     = (state_n == S_STAGE) && (state != S_STAGE);
    assign new_game   = (state == S_OVER) && (state_n == S_STAGE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= S_STAGE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_STAGE: if (spcKey) state_n = S_PLAY;
            // Player hit outranks a simultaneous clear of the last enemy
            S_PLAY:  if (plr_commit)     state_n = (scrLiv > 3'd1) ? S_DEAD : S_OVER;
                     else if (all_clear) state_n = S_STAGE;
            S_DEAD:  if (oneSec && dead_cnt == DW'(DEAD_SECS - 1)) state_n = S_PLAY;
            S_OVER:  if (spcKey) state_n = S_STAGE;
            default: state_n = S_STAGE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_inv  <= '0;
            pend_boss <= 1'b0;
            pend_plr  <= 1'b0;
            invExs    <= '1;
            invHit    <= '0;
            lrrExs    <= 1'b1;
            lrrHit    <= 1'b0;
            boss_ctr  <= BW'(BOSS_LIVES);
            plrHit    <= 1'b0;
            scrLiv    <= 3'(PLR_LIVES);
            btpKil    <= '0;
            btiKil    <= '0;
            dead_cnt  <= '0;
        end else begin
            invHit <= commit ? pend_inv : '0;
            lrrHit <= commit & pend_boss;
            plrHit <= plr_commit;
            btpKil <= btpReq & {PBOLTS{inv_det | boss_det}};
            btiKil <= btiReq & {IBOLTS{plr_raw}};

            // Hits seen on the commit cycle start the next frame's pend
            if (state_n != state) begin
                pend_inv  <= '0;
                pend_boss <= 1'b0;
                pend_plr  <= 1'b0;
            end else if (commit) begin
                pend_inv  <= det_vec;
                pend_boss <= boss_det;
                pend_plr  <= plr_det;
            end else begin
                pend_inv  <= pend_inv | det_vec;
                pend_boss <= pend_boss | boss_det;
                pend_plr  <= pend_plr | plr_det;
            end

            if (refill) begin
                invExs   <= '1;
                lrrExs   <= 1'b1;
                boss_ctr <= BW'(BOSS_LIVES);
            end else if (commit) begin
                invExs <= invExs & ~pend_inv;
                if (pend_boss) boss_ctr <= boss_ctr - BW'(1);
                if (boss_kill) lrrExs <= 1'b0;
            end

            if (new_game)        scrLiv <= 3'(PLR_LIVES);
            else if (plr_commit) scrLiv <= scrLiv - 3'd1;

            if (state != S_DEAD) dead_cnt <= '0;
            else if (oneSec)     dead_cnt <= dead_cnt + DW'(1);
        end
    end

    score_accum #(
        .N(INV_ROWS * INV_COLS), .SCORE_W(SCORE_W), .INV_PTS(INV_PTS), .BOSS_PTS(BOSS_PTS)
    ) u_score (
        .clk(clk), .resetN(resetN), .clr(new_game), .en(commit),
        .kills(pend_inv), .boss_kill(boss_kill), .score(scrNum)
    );

    assign stgMsg = (state == S_STAGE);
    assign scrMsg = (state == S_PLAY) || (state == S_DEAD);
    assign edgMsg = (state == S_OVER);
    assign plrExs = (state == S_STAGE) || (state == S_PLAY);

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

    logic clk = 1'b0, resetN = 1'b0;
    logic startOfFrame = 0, spcKey = 0, oneSec = 0, plrReq = 0, invReq = 0, lrrReq = 0, cheatput = 0;
    logic [10:0] invOSX = '0, invOSY = '0;
    logic [3:0] btpReq = '0, btiReq = '0;
    logic plrExs, plrHit, lrrExs, lrrHit, stgMsg, scrMsg, edgMsg;
    logic [7:0][15:0] invExs, invHit;
    logic [3:0] btpKil, btiKil;
    logic [9:0] scrNum;
    logic [2:0] scrLiv;

    game_state_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .spcKey(spcKey), .oneSec(oneSec),
        .plrReq(plrReq), .invReq(invReq), .invOSX(invOSX), .invOSY(invOSY), .lrrReq(lrrReq),
        .btpReq(btpReq), .btiReq(btiReq), .cheatput(cheatput),
        .plrExs(plrExs), .plrHit(plrHit), .invExs(invExs), .invHit(invHit),
        .lrrExs(lrrExs), .lrrHit(lrrHit), .btpKil(btpKil), .btiKil(btiKil),
        .stgMsg(stgMsg), .scrMsg(scrMsg), .edgMsg(edgMsg), .scrNum(scrNum), .scrLiv(scrLiv)
    );

    always #5 clk = ~clk;

    localparam int O_STG = 0, O_SCR = 1, O_EDG = 2, O_SCORE = 3, O_LIV = 4, O_PLREX = 5,
                   O_LRREX = 6, O_LRRHIT = 7, O_IH12 = 8, O_IX12 = 9, O_BTPK = 10,
                   O_BTIK = 11, O_PLRHIT = 12, O_INVCNT = 13, O_IHCNT = 14;

    int n_chk = 0, n_fail = 0;
    string tq[$];
    int    sq[$];
    int    vq[$];
    int    mscore;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            O_STG:    return int'(stgMsg);
            O_SCR:    return int'(scrMsg);
            O_EDG:    return int'(edgMsg);
            O_SCORE:  return int'(scrNum);
            O_LIV:    return int'(scrLiv);
            O_PLREX:  return int'(plrExs);
            O_LRREX:  return int'(lrrExs);
            O_LRRHIT: return int'(lrrHit);
            O_IH12:   return int'(invHit[1][2]);
            O_IX12:   return int'(invExs[1][2]);
            O_BTPK:   return int'(btpKil);
            O_BTIK:   return int'(btiKil);
            O_PLRHIT: return int'(plrHit);
            O_INVCNT: return $countones(invExs);
            O_IHCNT:  return $countones(invHit);
            default:  return -1;
        endcase
    endfunction

    task automatic expect_(input string tag, input int sel, input int val);
        tq.push_back(tag); sq.push_back(sel); vq.push_back(val);
    endtask

    task automatic drain();
        while (tq.size() > 0) begin
            string t; int s; int v;
            t = tq.pop_front(); s = sq.pop_front(); v = vq.pop_front();
            chk(t, obs(s), v);
        end
    endtask

    // inputs change at negedge; outputs observed on the following negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic clr_in();
        startOfFrame = 0; spcKey = 0; oneSec = 0; plrReq = 0; invReq = 0; lrrReq = 0;
        btpReq = '0; btiReq = '0; cheatput = 0;
    endtask

    task automatic hit_cell(input int r, input int c);
        btpReq = 4'b0001; invReq = 1; invOSX = 11'(c * 32 + 5); invOSY = 11'(r * 32 + 5);
        step(); clr_in();
    endtask

    task automatic frame();
        startOfFrame = 1; step(); clr_in();
    endtask

    task automatic plr_shot();
        btiReq = 4'b0001; plrReq = 1; step(); clr_in();
    endtask

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    initial begin
        // ---- reset ----
        repeat (3) @(negedge clk);
        expect_("rst_stg", O_STG, 1);   expect_("rst_scr", O_SCR, 0);
        expect_("rst_edg", O_EDG, 0);   expect_("rst_score", O_SCORE, 0);
        expect_("rst_liv", O_LIV, 3);   expect_("rst_plrex", O_PLREX, 1);
        expect_("rst_lrrex", O_LRREX, 1); expect_("rst_inv", O_INVCNT, 128);
        expect_("rst_ih", O_IHCNT, 0);  expect_("rst_btpk", O_BTPK, 0);
        drain();
        resetN = 1;
        @(negedge clk);

        // ---- start ----
        spcKey = 1;
        expect_("start_stg", O_STG, 0); expect_("start_scr", O_SCR, 1);
        expect_("start_liv", O_LIV, 3); expect_("start_score", O_SCORE, 0);
        step(); clr_in();

        // ---- single invader hit at (70,40) -> cell [1][2] ----
        btpReq = 4'b0001; invReq = 1; invOSX = 11'd70; invOSY = 11'd40;
        expect_("inv_btpk", O_BTPK, 1);
        step(); clr_in();
        expect_("inv_btpk_off", O_BTPK, 0); expect_("inv_nohit_yet", O_IX12, 1);
        step();
        startOfFrame = 1;
        expect_("inv_hit12", O_IH12, 1); expect_("inv_ex12", O_IX12, 0);
        expect_("inv_hitcnt", O_IHCNT, 1); expect_("inv_score", O_SCORE, 1);
        step(); clr_in();
        expect_("inv_hit_pulse", O_IHCNT, 0);
        step();

        // ---- out-of-range and dead-cell hits are ignored ----
        btpReq = 4'b0001; invReq = 1; invOSX = 11'd70; invOSY = 11'd300;
        expect_("oor_row", O_BTPK, 0); step();
        invOSX = 11'd600; invOSY = 11'd40;
        expect_("oor_col", O_BTPK, 0); step();
        invOSX = 11'd70; invOSY = 11'd40;
        expect_("dead_cell", O_BTPK, 0); step(); clr_in();
        startOfFrame = 1;
        expect_("oor_score", O_SCORE, 1); expect_("oor_inv", O_INVCNT, 127);
        step(); clr_in();

        // ---- boss: two bolts in one frame count as one hit ----
        btpReq = 4'b0011; lrrReq = 1;
        expect_("boss_btpk2", O_BTPK, 3); step();
        btpReq = 4'b0100;
        expect_("boss_btpk1", O_BTPK, 4); step(); clr_in();
        startOfFrame = 1;
        expect_("boss_hit1", O_LRRHIT, 1); expect_("boss_alive1", O_LRREX, 1);
        step(); clr_in();
        expect_("boss_hit_pulse", O_LRRHIT, 0); step();
        for (int k = 2; k <= 20; k++) begin
            btpReq = 4'b0001; lrrReq = 1; step(); clr_in();
            startOfFrame = 1;
            expect_("boss_hitk", O_LRRHIT, 1);
            if (k == 19) expect_("boss_alive19", O_LRREX, 1);
            if (k == 20) begin
                expect_("boss_dead", O_LRREX, 0); expect_("boss_score", O_SCORE, 11);
            end
            step(); clr_in();
        end
        btpReq = 4'b0001; lrrReq = 1;
        expect_("boss_gone_nokill", O_BTPK, 0); step(); clr_in();

        // ---- clear all but [0][0] in one frame ----
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                if (!(r == 0 && c == 0)) hit_cell(r, c);
        startOfFrame = 1;
        expect_("mass_score", O_SCORE, 137); expect_("mass_inv", O_INVCNT, 1);
        expect_("mass_ihcnt", O_IHCNT, 126); expect_("mass_play", O_SCR, 1);
        step(); clr_in();
        expect_("mass_still_play", O_STG, 0); step();

        // ---- last invader and player hit in the same frame ----
        hit_cell(0, 0);
        btiReq = 4'b0001; plrReq = 1;
        expect_("plr_btik", O_BTIK, 1); step(); clr_in();
        startOfFrame = 1;
        expect_("sim_plrhit", O_PLRHIT, 1); expect_("sim_liv", O_LIV, 2);
        expect_("sim_score", O_SCORE, 138); expect_("sim_plrex", O_PLREX, 0);
        expect_("sim_scr", O_SCR, 1); expect_("sim_stg", O_STG, 0);
        expect_("sim_inv", O_INVCNT, 0);
        step(); clr_in();

        // ---- dead timer ----
        oneSec = 1; step(); clr_in();
        expect_("dead1_plrex", O_PLREX, 0); step();
        oneSec = 1;
        expect_("dead2_plrex", O_PLREX, 1); expect_("dead2_stg", O_STG, 0);
        expect_("dead2_inv", O_INVCNT, 0);
        step(); clr_in();
        expect_("clear_stg", O_STG, 1); expect_("clear_inv", O_INVCNT, 128);
        expect_("clear_lrr", O_LRREX, 1); expect_("clear_liv", O_LIV, 2);
        expect_("clear_score", O_SCORE, 138);
        step();

        // ---- detection on the commit cycle lands in the next frame ----
        spcKey = 1; step(); clr_in();
        btpReq = 4'b0001; invReq = 1; invOSX = 11'd70; invOSY = 11'd40; startOfFrame = 1;
        expect_("sof_same_ih", O_IH12, 0); expect_("sof_same_ix", O_IX12, 1);
        expect_("sof_same_btpk", O_BTPK, 1);
        step(); clr_in();
        startOfFrame = 1;
        expect_("sof_next_ih", O_IH12, 1); expect_("sof_next_score", O_SCORE, 139);
        step(); clr_in();

        // ---- game over ----
        btiReq = 4'b0010; plrReq = 1;
        expect_("go_btik", O_BTIK, 2); step(); clr_in();
        startOfFrame = 1;
        expect_("go1_liv", O_LIV, 1); expect_("go1_plrex", O_PLREX, 0);
        step(); clr_in();
        oneSec = 1; step(); clr_in();
        oneSec = 1; step(); clr_in();
        plr_shot();
        startOfFrame = 1;
        expect_("go_edg", O_EDG, 1); expect_("go_liv", O_LIV, 0);
        expect_("go_scr", O_SCR, 0); expect_("go_plrex", O_PLREX, 0);
        expect_("go_score", O_SCORE, 139);
        step(); clr_in();
        spcKey = 1;
        expect_("new_stg", O_STG, 1); expect_("new_edg", O_EDG, 0);
        expect_("new_liv", O_LIV, 3); expect_("new_score", O_SCORE, 0);
        expect_("new_inv", O_INVCNT, 128); expect_("new_lrr", O_LRREX, 1);
        expect_("new_plrex", O_PLREX, 1);
        step(); clr_in();
        step();

        // ---- score saturation over several full stages ----
        mscore = 0;
        for (int s = 0; s < 10; s++) begin
            if (mscore == 1023) break;
            spcKey = 1; step(); clr_in();
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 16; c++) hit_cell(r, c);
            mscore = sat(mscore + 128);
            startOfFrame = 1;
            expect_("sat_inv_score", O_SCORE, mscore);
            step(); clr_in();
            for (int k = 1; k <= 20; k++) begin
                btpReq = 4'b1000; lrrReq = 1; step(); clr_in();
                if (k == 20) begin
                    mscore = sat(mscore + 10);
                    expect_("sat_boss_score", O_SCORE, mscore);
                    expect_("sat_stage", O_STG, 1);
                end
                frame();
            end
        end
        spcKey = 1; step(); clr_in();
        hit_cell(3, 3);
        startOfFrame = 1;
        expect_("sat_hold", O_SCORE, 1023); expect_("sat_kill_done", O_IHCNT, 1);
        step(); clr_in();

`ifdef GAME_CHEAT_EN
        btiReq = 4'b0001; plrReq = 1; cheatput = 1;
        expect_("cheat_btik", O_BTIK, 1); step(); clr_in();
        startOfFrame = 1;
        expect_("cheat_liv", O_LIV, 3); expect_("cheat_plrhit", O_PLRHIT, 0);
        expect_("cheat_plrex", O_PLREX, 1);
        step(); clr_in();
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
